// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive FCS path: CRC-32 constants
// and the per-frame status record.
package eth_rx_pkg;

  // Reflected CRC-32 (IEEE 802.3) constants.
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  // Register value left after running the CRC over a frame plus its own FCS.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int BYTE_CNT_W = 11;

  // Per-frame error summary; bit order matches the frame_status port.
  typedef struct packed {
    logic oversize;
    logic runt;
    logic mac_err;
    logic fcs_err;
  } rx_status_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected CRC-32, fully combinational
// (eight unrolled shift/xor stages). Shared with the transmit path.
module eth_crc32_byte
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte into the low bits, then shift out one bit per stage.
  always_comb begin
    logic [31:0] c;
    // NOTE: blocking assignments here on purpose -- each loop stage must see
    // the result of the previous one within the same evaluation.
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: runs CRC-32 over every byte, strips the 4-byte FCS
// with a 4-byte hold-back pipeline, flags bad frames on the final output
// byte and publishes per-frame status.
// Optional statistics counters are built when ETH_RX_STATS_EN is defined.
module eth_rx_fcs_check
  import eth_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int CNT_W   = 16
) (
  input  logic             rx_clk,
  input  logic             rst_int,
  input  logic [7:0]       s_rx_tdata,
  input  logic             s_rx_tvalid,
  input  logic             s_rx_tlast,
  input  logic             s_rx_tuser,
  output logic [7:0]       m_rx_tdata,
  output logic             m_rx_tvalid,
  output logic             m_rx_tlast,
  output logic             m_rx_tuser,
  output logic             frame_done,
  output logic [3:0]       frame_status,
  output logic [31:0]      rx_fcs_rcvd,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  input  logic             cnt_clr
);

  localparam logic [BYTE_CNT_W-1:0] MIN_LEN_C = BYTE_CNT_W'(MIN_LEN);
  localparam logic [BYTE_CNT_W-1:0] MAX_LEN_C = BYTE_CNT_W'(MAX_LEN);
  localparam logic [BYTE_CNT_W-1:0] CNT_SAT   = '1;

  logic [31:0]           crc_q;
  logic [31:0]           crc_next;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_inc;
  // Hold-back bytes: newest in [31:24], oldest in [7:0].
  logic [31:0]           hold_q;
  logic [31:0]           hold_shift;
  logic [2:0]            fill_q;
  logic                  mac_err_q;
  logic                  pop;
  rx_status_t            status_now;
  rx_status_t            status_q;
  logic                  done_q;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (s_rx_tdata),
    .crc_out (crc_next)
  );

  // Frame verdict as it would stand if the current beat were the last one.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through it can leave a value unassigned and infer a latch.
    status_now   = '0;
    byte_cnt_inc = (byte_cnt_q == CNT_SAT) ? byte_cnt_q : byte_cnt_q + BYTE_CNT_W'(1);
    hold_shift   = {s_rx_tdata, hold_q[31:8]};
    pop          = s_rx_tvalid && (fill_q == 3'd4);
    status_now.fcs_err  = (crc_next != CRC32_RESIDUE);
    status_now.mac_err  = mac_err_q | s_rx_tuser;
    status_now.runt     = (byte_cnt_inc < MIN_LEN_C);
    status_now.oversize = (byte_cnt_inc > MAX_LEN_C);
  end

  // Per-frame accumulation: CRC, byte count, hold-back fill, sticky MAC error.
  always_ff @(posedge rx_clk) begin
    // NOTE: non-blocking assignments for all registered state, so every
    // register samples the values from before this edge.
    if (rst_int) begin
      crc_q      <= CRC32_INIT;
      byte_cnt_q <= '0;
      hold_q     <= '0;
      fill_q     <= '0;
      mac_err_q  <= 1'b0;
    end else if (s_rx_tvalid) begin
      if (s_rx_tlast) begin
        crc_q      <= CRC32_INIT;
        byte_cnt_q <= '0;
        hold_q     <= '0;
        fill_q     <= '0;
        mac_err_q  <= 1'b0;
      end else begin
        crc_q      <= crc_next;
        byte_cnt_q <= byte_cnt_inc;
        hold_q     <= hold_shift;
        fill_q     <= (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
        mac_err_q  <= status_now.mac_err;
      end
    end
  end

  // Output stream: emit the oldest held byte once four newer ones exist.
  always_ff @(posedge rx_clk) begin
    if (rst_int) begin
      m_rx_tdata  <= '0;
      m_rx_tvalid <= 1'b0;
      m_rx_tlast  <= 1'b0;
      m_rx_tuser  <= 1'b0;
    end else begin
      m_rx_tvalid <= pop;
      m_rx_tlast  <= pop && s_rx_tlast;
      m_rx_tuser  <= pop && s_rx_tlast && (|status_now);
      if (pop) begin
        m_rx_tdata <= hold_q[7:0];
      end
    end
  end

  // End-of-frame reporting: done pulse, held status and received FCS bytes.
  always_ff @(posedge rx_clk) begin
    if (rst_int) begin
      done_q      <= 1'b0;
      status_q    <= '0;
      rx_fcs_rcvd <= '0;
    end else begin
      done_q <= s_rx_tvalid && s_rx_tlast;
      if (s_rx_tvalid && s_rx_tlast) begin
        status_q    <= status_now;
        rx_fcs_rcvd <= hold_shift;
      end
    end
  end

  assign frame_done   = done_q;
  assign frame_status = status_q;

`ifdef ETH_RX_STATS_EN
  // Saturating good/bad frame counters, updated the cycle frame_done is high;
  // a clear in that same cycle wins and the frame is not counted.
  always_ff @(posedge rx_clk) begin
    if (rst_int || cnt_clr) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (done_q) begin
      if (status_q == '0) begin
        if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
      end else begin
        if (bad_cnt != '1) bad_cnt <= bad_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign good_cnt       = '0;
  assign bad_cnt        = '0;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Self-checking bench for eth_rx_fcs_check. A second instance with 3-bit
// counters shares the input bus so counter saturation is reachable quickly.
module tb_eth_rx_fcs_check;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {logic [7:0] data; logic last; logic user;} out_beat_t;
  typedef struct packed {logic [3:0] status; logic [31:0] fcs;} done_rec_t;

`ifdef ETH_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        rx_clk = 1'b0;
  logic        rst_int;
  logic [7:0]  s_rx_tdata;
  logic        s_rx_tvalid, s_rx_tlast, s_rx_tuser, cnt_clr;
  logic [7:0]  m_rx_tdata;
  logic        m_rx_tvalid, m_rx_tlast, m_rx_tuser, frame_done;
  logic [3:0]  frame_status;
  logic [31:0] rx_fcs_rcvd;
  logic [15:0] good_cnt, bad_cnt;
  logic [7:0]  sat_tdata;
  logic        sat_tvalid, sat_tlast, sat_tuser, sat_done;
  logic [3:0]  sat_status;
  logic [31:0] sat_fcs;
  logic [2:0]  sat_good, sat_bad;

  always #4 rx_clk = ~rx_clk;

  eth_rx_fcs_check u_dut (
    .rx_clk(rx_clk), .rst_int(rst_int),
    .s_rx_tdata(s_rx_tdata), .s_rx_tvalid(s_rx_tvalid),
    .s_rx_tlast(s_rx_tlast), .s_rx_tuser(s_rx_tuser),
    .m_rx_tdata(m_rx_tdata), .m_rx_tvalid(m_rx_tvalid),
    .m_rx_tlast(m_rx_tlast), .m_rx_tuser(m_rx_tuser),
    .frame_done(frame_done), .frame_status(frame_status),
    .rx_fcs_rcvd(rx_fcs_rcvd), .good_cnt(good_cnt), .bad_cnt(bad_cnt),
    .cnt_clr(cnt_clr)
  );

  eth_rx_fcs_check #(.CNT_W(3)) u_sat (
    .rx_clk(rx_clk), .rst_int(rst_int),
    .s_rx_tdata(s_rx_tdata), .s_rx_tvalid(s_rx_tvalid),
    .s_rx_tlast(s_rx_tlast), .s_rx_tuser(s_rx_tuser),
    .m_rx_tdata(sat_tdata), .m_rx_tvalid(sat_tvalid),
    .m_rx_tlast(sat_tlast), .m_rx_tuser(sat_tuser),
    .frame_done(sat_done), .frame_status(sat_status),
    .rx_fcs_rcvd(sat_fcs), .good_cnt(sat_good), .bad_cnt(sat_bad),
    .cnt_clr(cnt_clr)
  );

  out_beat_t out_q[$];
  done_rec_t done_q[$];
  int checks = 0;
  int errors = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  // Capture the output stream and end-of-frame reports away from the active edge.
  always @(negedge rx_clk) begin
    if (!rst_int) begin
      if (m_rx_tvalid) out_q.push_back({m_rx_tdata, m_rx_tlast, m_rx_tuser});
      if (frame_done)  done_q.push_back({frame_status, rx_fcs_rcvd});
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_of(input byte_q_t q, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] last4(input byte_q_t f);
    int n = f.size();
    return {f[n-1], f[n-2], f[n-3], f[n-4]};
  endfunction

  function automatic logic [3:0] exp_status(input byte_q_t f, input bit mac);
    int   n = f.size();
    logic fcs_bad;
    if (n >= 4) fcs_bad = (~crc_of(f, n - 4)) != last4(f);
    else        fcs_bad = crc_of(f, n) != 32'hDEBB20E3;
    return {n > 1522, n < 64, mac, fcs_bad};
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic make_frame(input int plen, input bit good_fcs, output byte_q_t f);
    logic [31:0] fcs;
    f = {};
    for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
    fcs = ~crc_of(f, plen);
    if (!good_fcs) fcs = fcs ^ (32'h1 << $urandom_range(31));
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge rx_clk);
      s_rx_tvalid = 1'b0; s_rx_tlast = 1'b0; s_rx_tuser = 1'b0;
    end
  endtask

  task automatic drive_frame(input byte_q_t f, input int err_idx, input bit gaps);
    for (int i = 0; i < f.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(2) == 0) idle($urandom_range(1, 3));
      @(negedge rx_clk);
      s_rx_tvalid = 1'b1;
      s_rx_tdata  = f[i];
      s_rx_tlast  = (i == f.size() - 1);
      s_rx_tuser  = (i == err_idx);
    end
  endtask

  // ---------------- checkers ----------------
  task automatic check_frame(input string name, input byte_q_t f, input bit mac);
    int        n    = f.size();
    int        npay = (n >= 5) ? n - 4 : 0;
    logic [3:0] st  = exp_status(f, mac);
    out_beat_t ob;
    done_rec_t dr;
    for (int i = 0; i < npay; i++) begin
      checks++;
      if (out_q.size() == 0) begin
        errors++;
        $display("FAIL %s beat %0d: got no output beat, expected data %02h", name, i, f[i]);
        break;
      end
      ob = out_q.pop_front();
      if (ob.data !== f[i] || ob.last !== (i == npay - 1) ||
          (i == npay - 1 && ob.user !== (|st))) begin
        errors++;
        $display("FAIL %s beat %0d: got data %02h last %b user %b, expected data %02h last %b user %b",
                 name, i, ob.data, ob.last, ob.user, f[i], (i == npay - 1), (|st));
      end
    end
    checks++;
    if (done_q.size() == 0) begin
      errors++;
      $display("FAIL %s frame_done: got no pulse, expected one with status %04b", name, st);
    end else begin
      dr = done_q.pop_front();
      if (dr.status !== st) begin
        errors++;
        $display("FAIL %s status: got %04b, expected %04b", name, dr.status, st);
      end
      if (n >= 4) begin
        checks++;
        if (dr.fcs !== last4(f)) begin
          errors++;
          $display("FAIL %s rx_fcs_rcvd: got %08h, expected %08h", name, dr.fcs, last4(f));
        end
      end
    end
    if (st == 4'b0) exp_good++; else exp_bad++;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (out_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: got %0d beats %0d done pulses, expected 0 and 0",
               name, out_q.size(), done_q.size());
      out_q = {}; done_q = {};
    end
  endtask

  task automatic check_counters(input string name);
    int g16 = STATS ? sat(exp_good, 65535) : 0;
    int b16 = STATS ? sat(exp_bad, 65535)  : 0;
    int g3  = STATS ? sat(exp_good, 7)     : 0;
    int b3  = STATS ? sat(exp_bad, 7)      : 0;
    checks++;
    if (good_cnt !== 16'(g16) || bad_cnt !== 16'(b16)) begin
      errors++;
      $display("FAIL %s counters: got good %0d bad %0d, expected good %0d bad %0d",
               name, good_cnt, bad_cnt, g16, b16);
    end
    checks++;
    if (sat_good !== 3'(g3) || sat_bad !== 3'(b3)) begin
      errors++;
      $display("FAIL %s narrow counters: got good %0d bad %0d, expected good %0d bad %0d",
               name, sat_good, sat_bad, g3, b3);
    end
  endtask

  task automatic run_one(input string name, input byte_q_t f, input int err_idx, input bit gaps);
    drive_frame(f, err_idx, gaps);
    idle(4);
    check_frame(name, f, err_idx >= 0 && err_idx < f.size());
    check_drained(name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_int = 1'b1;
    idle(3);
    @(negedge rx_clk);
    rst_int = 1'b0;
    idle(2);
    checks++;
    if ({m_rx_tdata, m_rx_tvalid, m_rx_tlast, m_rx_tuser, frame_done, frame_status} !== 16'h0 ||
        rx_fcs_rcvd !== 32'h0 || good_cnt !== 16'h0 || bad_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset: got data %02h v%b l%b u%b done %b st %04b fcs %08h good %0d bad %0d, expected all 0",
               m_rx_tdata, m_rx_tvalid, m_rx_tlast, m_rx_tuser, frame_done, frame_status,
               rx_fcs_rcvd, good_cnt, bad_cnt);
    end
  endtask

  task automatic test_good_and_fcs_err();
    byte_q_t f, g;
    make_frame(60, 1'b1, f);
    run_one("good64", f, -1, 1'b0);
    check_counters("good64");
    g = f;
    g[10] = g[10] ^ 8'h01;
    run_one("fcs_err64", g, -1, 1'b0);
    check_counters("fcs_err64");
  endtask

  task automatic test_short_frames();
    byte_q_t f;
    for (int len = 1; len <= 4; len++) begin
      f = {};
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      run_one($sformatf("short%0d", len), f, -1, 1'b0);
    end
    make_frame(1, 1'b1, f);
    run_one("len5", f, -1, 1'b0);
    check_counters("short");
  endtask

  task automatic test_length_limits();
    byte_q_t f;
    make_frame(56, 1'b1, f);   run_one("runt60", f, -1, 1'b0);
    make_frame(59, 1'b1, f);   run_one("len63", f, -1, 1'b0);
    make_frame(1518, 1'b1, f); run_one("len1522", f, -1, 1'b0);
    make_frame(1519, 1'b1, f); run_one("len1523", f, -1, 1'b0);
    make_frame(1596, 1'b1, f); run_one("over1600", f, -1, 1'b0);
    check_counters("limits");
  endtask

  task automatic test_back_to_back();
    byte_q_t f1, f2;
    make_frame(60, 1'b1, f1);
    make_frame(60, 1'b1, f2);
    drive_frame(f1, -1, 1'b1);
    drive_frame(f2, 19, 1'b1);
    idle(4);
    check_frame("b2b_first", f1, 1'b0);
    check_frame("b2b_second", f2, 1'b1);
    check_drained("b2b");
    check_counters("b2b");
  endtask

  task automatic test_cnt_clr();
    byte_q_t f;
    make_frame(60, 1'b1, f);
    drive_frame(f, -1, 1'b0);
    @(negedge rx_clk);
    s_rx_tvalid = 1'b0; s_rx_tlast = 1'b0; s_rx_tuser = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL cnt_clr frame_done: got %b, expected 1", frame_done);
    end
    cnt_clr = 1'b1;
    @(negedge rx_clk);
    cnt_clr = 1'b0;
    idle(3);
    check_frame("cnt_clr", f, 1'b0);
    check_drained("cnt_clr");
    exp_good = 0;
    exp_bad  = 0;
    check_counters("cnt_clr");
  endtask

  task automatic test_saturation();
    byte_q_t f;
    for (int k = 0; k < 9; k++) begin
      make_frame(60, 1'b1, f);
      drive_frame(f, -1, 1'b0);
      idle(4);
      check_frame($sformatf("sat%0d", k), f, 1'b0);
    end
    check_drained("sat");
    check_counters("sat");
  endtask

  task automatic test_random();
    byte_q_t f;
    int      sel, err;
    for (int k = 0; k < 16; k++) begin
      sel = $urandom_range(9);
      if (sel == 0) begin
        f = {};
        repeat ($urandom_range(1, 4)) f.push_back(8'($urandom));
      end else if (sel <= 8) begin
        make_frame($urandom_range(1, 100), 1'($urandom), f);
      end else begin
        make_frame($urandom_range(1510, 1530), 1'($urandom), f);
      end
      err = ($urandom_range(3) == 0) ? $urandom_range(f.size() - 1) : -1;
      run_one($sformatf("rand%0d", k), f, err, 1'($urandom));
    end
    check_counters("random");
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t f;
    bit      saw_last = 1'b0;
    make_frame(60, 1'b1, f);
    for (int i = 0; i < 30; i++) begin
      @(negedge rx_clk);
      s_rx_tvalid = 1'b1; s_rx_tdata = f[i]; s_rx_tlast = 1'b0; s_rx_tuser = 1'b0;
    end
    @(negedge rx_clk);
    s_rx_tvalid = 1'b0;
    rst_int = 1'b1;
    idle(2);
    @(negedge rx_clk);
    rst_int = 1'b0;
    idle(3);
    foreach (out_q[i]) if (out_q[i].last) saw_last = 1'b1;
    checks++;
    if (saw_last || done_q.size() != 0 || frame_status !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid: got tlast %b done %0d status %04b, expected 0 0 0000",
               saw_last, done_q.size(), frame_status);
    end
    out_q = {}; done_q = {};
    exp_good = 0;
    exp_bad  = 0;
    check_counters("reset_mid");
    make_frame(60, 1'b1, f);
    run_one("after_reset", f, -1, 1'b1);
    check_counters("after_reset");
  endtask

  initial begin
    rst_int = 1'b1; cnt_clr = 1'b0;
    s_rx_tdata = '0; s_rx_tvalid = 1'b0; s_rx_tlast = 1'b0; s_rx_tuser = 1'b0;
    test_reset();
    test_good_and_fcs_err();
    test_short_frames();
    test_length_limits();
    test_back_to_back();
    test_cnt_clr();
    test_saturation();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
